dmux8way16_buf: RTL and testbench
=================================

Name: dmux8way16_buf

Overview:
- Registered 16-bit, 8-way demultiplexer: the write-side counterpart of mux8way16.
- Accepts one word per cycle through a valid/ready handshake.
- Steers each accepted word into one of eight output slots (a..h), chosen either by an explicit sel or by an internal auto-increment pointer.
- Each slot holds its word and a valid flag until the downstream consumer acknowledges it. Feeds slot-based consumers such as the RAM8 write path and banked register stages.

Parameters:
WIDTH, 16, data width of the input and of each slot register
RESET_VAL, 0, value loaded into every slot data register on reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in  in  WIDTH  input data word
in_valid  in  1  producer has a word on in this cycle
sel  in  3  target slot when auto=0 (0=a ... 7=h)
auto  in  1  1 = target is internal ptr; 0 = target is sel
in_ready  out  1  target slot can accept this cycle
a,b,c,d,e,f,g,h  out  WIDTH each  slot data registers (a=slot 0 ... h=slot 7)
valid  out  8  bit i = slot i holds unconsumed data
ack  in  8  bit i = consumer takes slot i this cycle
ptr  out  3  current auto-mode pointer
level  out  4  number of set bits in valid (0..8)
full  out  1  all eight valid bits set

Behaviour:
- One clock (clk). Reset is synchronous and active-high on reset, sampled only at the rising edge of clk.
- Reset, synchronous:
  - a..h = RESET_VAL, valid = 0, ptr = 0.
  - level and full are combinational from valid, so after reset level = 0 and full = 0.
  - in_ready = 1 after reset, because the target slot is empty.
  - Reset has priority over every other event: a transfer or ack in the reset cycle is discarded.
- Target selection: t = auto ? ptr : sel. Combinational.
- in_ready = ~valid[t] | ack[t]. Combinational, so a slot being drained may be refilled in the same cycle. in_ready is driven even when in_valid = 0.
- Transfer occurs when in_valid & in_ready at the rising edge:
  - slot[t] <= in and valid[t] <= 1, visible the next cycle (1-cycle latency).
  - Only slot t is written; other slots keep data and valid.
- Pointer:
  - ptr increments by 1 on each transfer with auto = 1, wrapping 7 -> 0.
  - Transfers with auto = 0 never move ptr.
  - ptr does not advance on a stalled cycle (in_valid & ~in_ready).
- ack, per slot i, evaluated independently in the same edge:
  - ack[i] & valid[i] & no write to i -> valid[i] <= 0.
  - ack[i] & write to i in the same cycle -> write wins: valid[i] stays 1, data is the new word.
  - ack[i] on an already-empty slot is ignored.
  - Multiple ack bits in one cycle are allowed.
- Slot data is not cleared by ack; it holds its last value until overwritten or reset.
- Stall: in_valid & ~in_ready means no state change from the input side. The producer must hold in and sel/auto stable until accepted.
- Switching auto mid-stream is legal. ptr keeps its value while auto = 0 and resumes from it when auto returns to 1.
- Full: full = 1 when valid = 8'hFF. in_ready is then 1 only if ack[t] = 1 in that cycle.
- No combinational path from in to any output; a..h, valid and ptr are registered.

Test Plan:
- Reset then addressed writes:
  - Stimulus: reset 1 cycle; auto=0, write 16'h1111 sel=0 through 16'h8888 sel=7 on consecutive cycles.
  - Required: each slot shows its word one cycle after acceptance; final valid=8'hFF, level=8, full=1, ptr=0.
- Auto mode with wrap:
  - Stimulus: auto=1, 10 back-to-back words 16'h0001..16'h000A, acking each slot 2 cycles after it fills.
  - Required: slots 0..7 get 1..8; slot 0 then gets 9 and slot 1 gets 10; ptr=2 at the end.
- Backpressure:
  - Stimulus: fill slot 3 via sel=3 (16'hBEEF); present 16'hCAFE to sel=3 with no ack.
  - Required: in_ready=0, d stays 16'hBEEF. Assert ack[3] -> in_ready=1 that cycle; next cycle d=16'hCAFE and valid[3]=1.
- Simultaneous ack and write on another slot:
  - Stimulus: slots 0 and 1 valid; in one cycle ack[0]=1 and write sel=1 with ack[1]=1, in=16'h5A5A.
  - Required: valid[0]=0, valid[1]=1, b=16'h5A5A, level drops by 1.
- Reset mid-operation:
  - Stimulus: auto=1, after 5 writes (ptr=5) assert reset together with in_valid=1.
  - Required: next cycle valid=0, ptr=0, a..h=RESET_VAL, level=0, the word is not stored, in_ready=1.
- Spurious ack and auto toggle:
  - Stimulus: ack=8'hFF when empty; then auto=1 write x2, auto=0 write sel=6, auto=1 write.
  - Required: the spurious ack has no effect; the auto writes land in slots 0, 1 and then 2 (ptr unaffected by the sel=6 write); g holds the sel=6 word.

Source files
------------

// File: rtl/dmux8way16_buf.sv
// Registered 8-way demultiplexer with per-slot valid/ack handshake.
// Each accepted word is steered to slot sel (auto=0) or to an auto-increment pointer (auto=1).
module dmux8way16_buf #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic [2:0]       sel,
  input  logic             auto,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [7:0]       valid,
  input  logic [7:0]       ack,
  output logic [2:0]       ptr,
  output logic [3:0]       level,
  output logic             full
);

  logic [WIDTH-1:0] slot_r [8];
  logic [2:0]       tgt_s;
  logic             xfer_s;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // A slot being acked this cycle counts as free, so it can be refilled in the same edge.
  assign tgt_s    = auto ? ptr : sel;
  assign in_ready = ~valid[tgt_s] | ack[tgt_s];
  assign xfer_s   = in_valid & in_ready;

  assign level = popcount8(valid);
  assign full  = &valid;

  assign a = slot_r[0];
  assign b = slot_r[1];
  assign c = slot_r[2];
  assign d = slot_r[3];
  assign e = slot_r[4];
  assign f = slot_r[5];
  assign g = slot_r[6];
  assign h = slot_r[7];

  // Slot data, valid flags and auto pointer; a write to a slot beats an ack on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        slot_r[i] <= RESET_VAL;
      end
      valid <= 8'h00;
      ptr   <= 3'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (xfer_s && (tgt_s == 3'(i))) begin
          slot_r[i] <= in;
          valid[i]  <= 1'b1;
        end else if (ack[i]) begin
          valid[i]  <= 1'b0;
        end else begin
          valid[i]  <= valid[i];
        end
      end
      if (xfer_s && auto) begin
        ptr <= ptr + 3'd1;
      end else begin
        ptr <= ptr;
      end
    end
  end

endmodule

// File: tb/tb_dmux8way16_buf.sv
// Self-checking bench for dmux8way16_buf: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a slot-array reference model.
module tb_dmux8way16_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        in_valid;
  logic [2:0]  sel;
  logic        auto;
  logic        in_ready;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [7:0]  valid;
  logic [7:0]  ack;
  logic [2:0]  ptr;
  logic [3:0]  level;
  logic        full;

  int checks = 0;
  int errors = 0;

  dmux8way16_buf #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .sel(sel), .auto(auto),
    .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .valid(valid), .ack(ack), .ptr(ptr), .level(level), .full(full)
  );

  always #5 clk = ~clk;

  logic [15:0] outs [8];
  assign outs[0] = a; assign outs[1] = b; assign outs[2] = c; assign outs[3] = d;
  assign outs[4] = e; assign outs[5] = f; assign outs[6] = g; assign outs[7] = h;

  // Reference model: an array of words, an array of occupied flags and a pointer.
  logic [15:0] md [8];
  bit          mv [8];
  int          mptr  = 0;
  bit          armed = 0;
  bit          stall_m = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    automatic int t = auto ? int'(sel) : 0;
    automatic bit rdy;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin md[i] = 16'h0000; mv[i] = 0; end
      mptr = 0;
      armed = 1;
      stall_m = 0;
    end else begin
      t = auto ? mptr : int'(sel);
      rdy = !mv[t] || ack[t];
      stall_m = in_valid && !rdy;
      for (int i = 0; i < 8; i++) if (ack[i]) mv[i] = 0;
      if (in_valid && rdy) begin
        md[t] = in;
        mv[t] = 1;
        if (auto) mptr = (mptr + 1) % 8;
      end
    end
  end

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      automatic int cnt = 0;
      automatic int t = auto ? mptr : int'(sel);
      automatic logic [7:0] ev = 8'h00;
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("model_slot%0d", i), outs[i], md[i]);
        ev[i] = mv[i];
        cnt += int'(mv[i]);
      end
      chk("model_valid", {8'h00, valid}, {8'h00, ev});
      chk("model_ptr", {13'h0, ptr}, 16'(mptr));
      chk("model_level", {12'h0, level}, 16'(cnt));
      chk("model_full", {15'h0, full}, {15'h0, (cnt == 8)});
      chk("model_in_ready", {15'h0, in_ready}, {15'h0, (!mv[t] || ack[t])});
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in = 16'h0000; in_valid = 1'b0; sel = 3'd0; auto = 1'b0; ack = 8'h00;
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("rst_valid", {8'h00, valid}, 16'h0000);
    chk("rst_level", {12'h0, level}, 16'h0000);
    chk("rst_ready", {15'h0, in_ready}, 16'h0001);
    chk("rst_a", a, 16'h0000);

    // Addressed writes to every slot
    auto = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      in  = 16'h1111 * 16'(i + 1);
      cycle();
      chk($sformatf("addr_slot%0d", i), outs[i], 16'h1111 * 16'(i + 1));
    end
    in_valid = 1'b0;
    #1;
    chk("addr_valid", {8'h00, valid}, 16'h00FF);
    chk("addr_level", {12'h0, level}, 16'h0008);
    chk("addr_full", {15'h0, full}, 16'h0001);
    chk("addr_ptr", {13'h0, ptr}, 16'h0000);
    chk("full_not_ready", {15'h0, in_ready}, 16'h0000);

    // Drain, then auto mode with wrap, each slot acked two cycles after it fills
    ack = 8'hFF; cycle(); ack = 8'h00;
    auto = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (cyc < 10);
      in = 16'(cyc + 1);
      ack = 8'h00;
      if (cyc >= 2) ack[(cyc - 2) % 8] = 1'b1;
      #1;
      if (cyc < 10) chk("auto_ready", {15'h0, in_ready}, 16'h0001);
      cycle();
    end
    in_valid = 1'b0; ack = 8'h00;
    #1;
    chk("auto_a", a, 16'h0009);
    chk("auto_b", b, 16'h000A);
    chk("auto_c", c, 16'h0003);
    chk("auto_h", h, 16'h0008);
    chk("auto_ptr", {13'h0, ptr}, 16'h0002);

    // Backpressure on slot 3
    auto = 1'b0; sel = 3'd3; in = 16'hBEEF; in_valid = 1'b1;
    cycle();
    in = 16'hCAFE;
    #1;
    chk("bp_stall_ready", {15'h0, in_ready}, 16'h0000);
    cycle();
    chk("bp_hold_d", d, 16'hBEEF);
    ack = 8'h08;
    #1;
    chk("bp_ack_ready", {15'h0, in_ready}, 16'h0001);
    cycle();
    ack = 8'h00; in_valid = 1'b0;
    #1;
    chk("bp_new_d", d, 16'hCAFE);
    chk("bp_valid3", {15'h0, valid[3]}, 16'h0001);

    // Ack slot 0 while slot 1 is acked and rewritten
    in_valid = 1'b1; sel = 3'd0; in = 16'h1234; cycle();
    sel = 3'd1; in = 16'h5678; cycle();
    in_valid = 1'b0;
    #1;
    chk("sim_level_pre", {12'h0, level}, 16'h0003);
    ack = 8'h03; sel = 3'd1; in = 16'h5A5A; in_valid = 1'b1;
    cycle();
    ack = 8'h00; in_valid = 1'b0;
    #1;
    chk("sim_valid0", {15'h0, valid[0]}, 16'h0000);
    chk("sim_valid1", {15'h0, valid[1]}, 16'h0001);
    chk("sim_b", b, 16'h5A5A);
    chk("sim_level", {12'h0, level}, 16'h0002);

    // Reset in the middle of auto traffic
    reset = 1'b1; cycle(); reset = 1'b0;
    auto = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin in = 16'h7000 + 16'(i); cycle(); end
    chk("mid_ptr5", {13'h0, ptr}, 16'h0005);
    reset = 1'b1; in = 16'hDEAD;
    cycle();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_valid", {8'h00, valid}, 16'h0000);
    chk("mid_ptr", {13'h0, ptr}, 16'h0000);
    chk("mid_a", a, 16'h0000);
    chk("mid_f", f, 16'h0000);
    chk("mid_level", {12'h0, level}, 16'h0000);
    chk("mid_ready", {15'h0, in_ready}, 16'h0001);

    // Spurious ack on empty slots, then auto toggling around an addressed write
    ack = 8'hFF; cycle(); ack = 8'h00;
    chk("spur_valid", {8'h00, valid}, 16'h0000);
    in_valid = 1'b1;
    auto = 1'b1; in = 16'h6001; cycle();
    in = 16'h6002; cycle();
    auto = 1'b0; sel = 3'd6; in = 16'h6006; cycle();
    auto = 1'b1; in = 16'h6003; cycle();
    in_valid = 1'b0;
    #1;
    chk("tog_a", a, 16'h6001);
    chk("tog_b", b, 16'h6002);
    chk("tog_c", c, 16'h6003);
    chk("tog_g", g, 16'h6006);
    chk("tog_ptr", {13'h0, ptr}, 16'h0003);

    // Randomized traffic; producer holds its word while stalled
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!stall_m) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in       = 16'($urandom);
        sel      = 3'($urandom_range(0, 7));
        auto     = ($urandom_range(0, 1) == 1);
      end
      ack = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      cycle();
    end
    reset = 1'b0; in_valid = 1'b0; ack = 8'h00;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
